// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - instruction sequencer and 4x4 register file driving the 4-bit ALU
module alu_sequencer #(
  parameter int NREG = 4,
  parameter int W    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [3:0]   instr_op,
  input  logic [1:0]   instr_rd,
  input  logic [1:0]   instr_rs1,
  input  logic [1:0]   instr_rs2,
  input  logic [W-1:0] instr_imm,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [W-1:0] alu_f3,
  input  logic [W-1:0] alu_f4,
  input  logic         alu_c,
  input  logic         alu_v,
  output logic         done,
  output logic         flag_c,
  output logic         flag_v,
  output logic         illegal,
  input  logic [1:0]   dbg_sel,
  output logic [W-1:0] dbg_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OPER = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [3:0] OP_LDI  = 4'b0000;
  localparam logic [3:0] OP_MUL  = 4'b0111;
  localparam logic [3:0] SEL_IDL = 4'b1111;

  logic [1:0]   r_state;
  logic [W-1:0] r_rf [NREG];
  logic [3:0]   r_op;
  logic [1:0]   r_rd;
  logic [1:0]   r_rs1;
  logic [1:0]   r_rs2;
  logic [W-1:0] r_imm;
  logic [W-1:0] r_alu_a;
  logic [W-1:0] r_alu_b;
  logic [3:0]   r_alu_sel;
  logic [W-1:0] r_f3;
  logic [W-1:0] r_f4;
  logic         r_c;
  logic         r_v;
  logic         r_flag_c;
  logic         r_flag_v;
  logic         r_illegal;

  logic         w_is_alu;
  logic         w_is_ldi;
  logic [1:0]   w_rd_hi;

  // Classify the latched opcode: ALU op (incl. the zero ops), LDI, or illegal
  always_comb begin
    w_is_ldi = (r_op == OP_LDI);
    case (r_op)
      4'b0001, 4'b0011, 4'b0111, 4'b1000, 4'b1001,
      4'b1011, 4'b1100, 4'b1110, 4'b1111: w_is_alu = 1'b1;
      default:                            w_is_alu = 1'b0;
    endcase
  end

  // MUL high nibble lands in the next register up, wrapping r3 -> r0
  assign w_rd_hi = r_rd + 2'd1;

  // Four-phase instruction FSM with register-file and flag writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_op      <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_imm     <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= SEL_IDL;
      r_f3      <= '0;
      r_f4      <= '0;
      r_c       <= 1'b0;
      r_v       <= 1'b0;
      r_flag_c  <= 1'b0;
      r_flag_v  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_op    <= instr_op;
            r_rd    <= instr_rd;
            r_rs1   <= instr_rs1;
            r_rs2   <= instr_rs2;
            r_imm   <= instr_imm;
            r_state <= S_OPER;
          end
        end
        S_OPER: begin
          r_alu_a   <= r_rf[r_rs1];
          r_alu_b   <= r_rf[r_rs2];
          r_alu_sel <= w_is_alu ? r_op : SEL_IDL;
          r_state   <= w_is_alu ? S_EXEC : S_WB;
        end
        S_EXEC: begin
          r_f3    <= alu_f3;
          r_f4    <= alu_f4;
          r_c     <= alu_c;
          r_v     <= alu_v;
          r_state <= S_WB;
        end
        default: begin
          if (w_is_alu) begin
            r_rf[r_rd] <= r_f3;
            r_flag_c   <= r_c;
            r_flag_v   <= r_v;
            if (r_op == OP_MUL) r_rf[w_rd_hi] <= r_f4;
          end else if (w_is_ldi) begin
            r_rf[r_rd] <= r_imm;
          end else begin
            r_illegal  <= 1'b1;
          end
          r_alu_sel <= SEL_IDL;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign done        = (r_state == S_WB);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_sel     = r_alu_sel;
  assign flag_c      = r_flag_c;
  assign flag_v      = r_flag_v;
  assign illegal     = r_illegal;
  assign dbg_data    = r_rf[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;

  logic       clk;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [1:0] instr_rd;
  logic [1:0] instr_rs1;
  logic [1:0] instr_rs2;
  logic [3:0] instr_imm;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_sel;
  logic [3:0] alu_f3;
  logic [3:0] alu_f4;
  logic       alu_c;
  logic       alu_v;
  logic       done;
  logic       flag_c;
  logic       flag_v;
  logic       illegal;
  logic [1:0] dbg_sel;
  logic [3:0] dbg_data;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.NREG(4), .W(4)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_f3(alu_f3), .alu_f4(alu_f4), .alu_c(alu_c), .alu_v(alu_v),
    .done(done), .flag_c(flag_c), .flag_v(flag_v), .illegal(illegal),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 4-bit ALU: carry is the raw carry-out, SUB is A + ~B + 1
  logic [4:0] m_sum;
  logic [7:0] m_prod;
  always_comb begin
    alu_f3 = 4'h0;
    alu_f4 = 4'h0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    m_sum  = 5'h0;
    m_prod = 8'h0;
    case (alu_sel)
      4'b0001: begin
        m_sum  = {1'b0, alu_a} + {1'b0, alu_b};
        alu_f3 = m_sum[3:0];
        alu_c  = m_sum[4];
        alu_v  = (alu_a[3] == alu_b[3]) && (m_sum[3] != alu_a[3]);
      end
      4'b0011: begin
        m_sum  = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_f3 = m_sum[3:0];
        alu_c  = m_sum[4];
        alu_v  = (alu_a[3] != alu_b[3]) && (m_sum[3] != alu_a[3]);
      end
      4'b0111: begin
        m_prod = alu_a * alu_b;
        alu_f3 = m_prod[3:0];
        alu_f4 = m_prod[7:4];
      end
      4'b1000: alu_f3 = ~(alu_a & alu_b);
      4'b1001: alu_f3 = ~(alu_a | alu_b);
      4'b1011: alu_f3 = alu_a ^ alu_b;
      default: alu_f3 = 4'h0;
    endcase
  end

  // Issue one instruction; lat = cycles from accept to done (-1 on timeout), sel_exec = alu_sel in EXEC
  task automatic run_instr(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                           input logic [1:0] rs2, input logic [3:0] imm,
                           output int lat, output logic [3:0] sel_exec);
    bit got;
    lat      = -1;
    sel_exec = 4'hx;
    got      = 1'b0;
    instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    instr_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (instr_ready) got = 1'b1;
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    if (got) begin
      for (int n = 1; n <= 8; n++) begin
        @(negedge clk);
        if (n == 2) sel_exec = alu_sel;
        if (done) begin
          lat = n;
          break;
        end
      end
    end
  endtask

  task automatic read_reg(input logic [1:0] idx, output logic [3:0] val);
    dbg_sel = idx;
    #1 val = dbg_data;
  endtask

  task automatic test_reset;
    logic [3:0] v;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", instr_ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (alu_sel !== 4'hF) begin errors++; $display("FAIL rst_sel got %h want f", alu_sel); end
    checks++; if ({alu_a, alu_b} !== 8'h00) begin errors++; $display("FAIL rst_ab got %h want 00", {alu_a, alu_b}); end
    checks++; if ({flag_c, flag_v, illegal} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {flag_c, flag_v, illegal}); end
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], v);
      checks++; if (v !== 4'h0) begin errors++; $display("FAIL rst_reg%0d got %h want 0", i, v); end
    end
  endtask

  task automatic test_ldi;
    int lat; logic [3:0] s; logic [3:0] v;
    run_instr(4'b0000, 2'd0, 2'd0, 2'd0, 4'h5, lat, s);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ldi0_lat got %0d want 2", lat); end
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL ldi0_ready_after got %b want 1", instr_ready); end
    run_instr(4'b0000, 2'd1, 2'd0, 2'd0, 4'h3, lat, s);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ldi1_lat got %0d want 2", lat); end
    @(negedge clk);
    read_reg(2'd0, v);
    checks++; if (v !== 4'h5) begin errors++; $display("FAIL ldi_r0 got %h want 5", v); end
    read_reg(2'd1, v);
    checks++; if (v !== 4'h3) begin errors++; $display("FAIL ldi_r1 got %h want 3", v); end
    checks++; if ({flag_c, flag_v} !== 2'b00) begin errors++; $display("FAIL ldi_flags got %b want 00", {flag_c, flag_v}); end
  endtask

  task automatic test_add;
    int lat; logic [3:0] s; logic [3:0] v;
    run_instr(4'b0000, 2'd0, 2'd0, 2'd0, 4'h7, lat, s);
    run_instr(4'b0000, 2'd1, 2'd0, 2'd0, 4'h9, lat, s);
    run_instr(4'b0001, 2'd2, 2'd0, 2'd1, 4'h0, lat, s);
    checks++; if (lat !== 3) begin errors++; $display("FAIL add_lat got %0d want 3", lat); end
    checks++; if (s !== 4'b0001) begin errors++; $display("FAIL add_sel_exec got %b want 0001", s); end
    @(negedge clk);
    read_reg(2'd2, v);
    checks++; if (v !== 4'h0) begin errors++; $display("FAIL add_r2 got %h want 0", v); end
    checks++; if ({flag_c, flag_v} !== 2'b10) begin errors++; $display("FAIL add_flags got %b want 10", {flag_c, flag_v}); end
    // 7 + 1 = 8: signed overflow, no carry; result into r3
    run_instr(4'b0000, 2'd1, 2'd0, 2'd0, 4'h1, lat, s);
    run_instr(4'b0001, 2'd3, 2'd0, 2'd1, 4'h0, lat, s);
    @(negedge clk);
    read_reg(2'd3, v);
    checks++; if (v !== 4'h8) begin errors++; $display("FAIL addv_r3 got %h want 8", v); end
    checks++; if ({flag_c, flag_v} !== 2'b01) begin errors++; $display("FAIL addv_flags got %b want 01", {flag_c, flag_v}); end
    // LDI leaves flags untouched
    run_instr(4'b0000, 2'd2, 2'd0, 2'd0, 4'hB, lat, s);
    @(negedge clk);
    checks++; if ({flag_c, flag_v} !== 2'b01) begin errors++; $display("FAIL ldi_keeps_flags got %b want 01", {flag_c, flag_v}); end
  endtask

  task automatic test_sub;
    int lat; logic [3:0] s; logic [3:0] v;
    run_instr(4'b0000, 2'd0, 2'd0, 2'd0, 4'h2, lat, s);
    run_instr(4'b0000, 2'd1, 2'd0, 2'd0, 4'h3, lat, s);
    run_instr(4'b0011, 2'd2, 2'd0, 2'd1, 4'h0, lat, s);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sub_lat got %0d want 3", lat); end
    @(negedge clk);
    read_reg(2'd2, v);
    checks++; if (v !== 4'hF) begin errors++; $display("FAIL sub_r2 got %h want f", v); end
    checks++; if ({flag_c, flag_v} !== 2'b00) begin errors++; $display("FAIL sub_flags got %b want 00", {flag_c, flag_v}); end
  endtask

  task automatic test_mul;
    int lat; logic [3:0] s; logic [3:0] v;
    run_instr(4'b0000, 2'd0, 2'd0, 2'd0, 4'hF, lat, s);
    run_instr(4'b0000, 2'd1, 2'd0, 2'd0, 4'hF, lat, s);
    run_instr(4'b0111, 2'd3, 2'd0, 2'd1, 4'h0, lat, s);
    checks++; if (lat !== 3) begin errors++; $display("FAIL mul_lat got %0d want 3", lat); end
    @(negedge clk);
    read_reg(2'd3, v);
    checks++; if (v !== 4'h1) begin errors++; $display("FAIL mul_r3 got %h want 1", v); end
    read_reg(2'd0, v);
    checks++; if (v !== 4'hE) begin errors++; $display("FAIL mul_r0_wrap got %h want e", v); end
    read_reg(2'd1, v);
    checks++; if (v !== 4'hF) begin errors++; $display("FAIL mul_r1_kept got %h want f", v); end
    checks++; if ({flag_c, flag_v} !== 2'b00) begin errors++; $display("FAIL mul_flags got %b want 00", {flag_c, flag_v}); end
  endtask

  task automatic test_illegal;
    int lat; logic [3:0] s; logic [3:0] v;
    // Set carry so an unwanted flag write would show: 7 + 9
    run_instr(4'b0000, 2'd0, 2'd0, 2'd0, 4'h7, lat, s);
    run_instr(4'b0000, 2'd1, 2'd0, 2'd0, 4'h9, lat, s);
    run_instr(4'b0001, 2'd2, 2'd0, 2'd1, 4'h0, lat, s);
    run_instr(4'b0000, 2'd3, 2'd0, 2'd0, 4'h4, lat, s);
    run_instr(4'b0101, 2'd2, 2'd0, 2'd1, 4'h0, lat, s);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ill_lat got %0d want 2", lat); end
    @(negedge clk);
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_sticky got %b want 1", illegal); end
    checks++; if ({flag_c, flag_v} !== 2'b10) begin errors++; $display("FAIL ill_flags got %b want 10", {flag_c, flag_v}); end
    read_reg(2'd2, v);
    checks++; if (v !== 4'h0) begin errors++; $display("FAIL ill_r2 got %h want 0", v); end
    read_reg(2'd3, v);
    checks++; if (v !== 4'h4) begin errors++; $display("FAIL ill_r3 got %h want 4", v); end
    run_instr(4'b0000, 2'd0, 2'd0, 2'd0, 4'hA, lat, s);
    run_instr(4'b0000, 2'd1, 2'd0, 2'd0, 4'h6, lat, s);
    run_instr(4'b1011, 2'd2, 2'd0, 2'd1, 4'h0, lat, s);
    checks++; if (lat !== 3) begin errors++; $display("FAIL xor_lat got %0d want 3", lat); end
    @(negedge clk);
    read_reg(2'd2, v);
    checks++; if (v !== 4'hC) begin errors++; $display("FAIL xor_r2 got %h want c", v); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL xor_ill_kept got %b want 1", illegal); end
    checks++; if ({flag_c, flag_v} !== 2'b00) begin errors++; $display("FAIL xor_flags got %b want 00", {flag_c, flag_v}); end
    // Zero op 1100 is legal: takes the ALU path, writes 0
    run_instr(4'b1100, 2'd0, 2'd0, 2'd1, 4'h0, lat, s);
    checks++; if (lat !== 3) begin errors++; $display("FAIL zop_lat got %0d want 3", lat); end
    @(negedge clk);
    read_reg(2'd0, v);
    checks++; if (v !== 4'h0) begin errors++; $display("FAIL zop_r0 got %h want 0", v); end
  endtask

  task automatic test_back_to_back;
    int acc; int dones; logic [3:0] v;
    int lat; logic [3:0] s;
    run_instr(4'b0000, 2'd0, 2'd0, 2'd0, 4'h2, lat, s);
    run_instr(4'b0000, 2'd1, 2'd0, 2'd0, 4'h5, lat, s);
    acc = 0; dones = 0;
    instr_op = 4'b0001; instr_rd = 2'd3; instr_rs1 = 2'd0; instr_rs2 = 2'd1; instr_imm = 4'h0;
    instr_valid = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (instr_ready && instr_valid) acc++;
      if (done) begin
        dones++;
        instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    checks++; if (acc !== 1) begin errors++; $display("FAIL hold_accepts got %0d want 1", acc); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL hold_dones got %0d want 1", dones); end
    read_reg(2'd3, v);
    checks++; if (v !== 4'h7) begin errors++; $display("FAIL hold_r3 got %h want 7", v); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [3:0] s; logic [3:0] v; bit got; int dseen;
    run_instr(4'b0000, 2'd0, 2'd0, 2'd0, 4'h7, lat, s);
    run_instr(4'b0000, 2'd1, 2'd0, 2'd0, 4'h9, lat, s);
    run_instr(4'b0001, 2'd3, 2'd0, 2'd1, 4'h0, lat, s);
    instr_op = 4'b0001; instr_rd = 2'd2; instr_rs1 = 2'd0; instr_rs2 = 2'd1;
    instr_valid = 1'b1;
    got = 1'b0; dseen = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (instr_ready) got = 1'b1;
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    if (done) dseen++;
    @(negedge clk);
    if (done) dseen++;
    checks++; if (alu_sel !== 4'b0001) begin errors++; $display("FAIL mid_sel_exec got %b want 0001", alu_sel); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    if (done) dseen++;
    checks++; if (dseen !== 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", dseen); end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", instr_ready); end
    checks++; if (alu_sel !== 4'hF) begin errors++; $display("FAIL mid_sel got %h want f", alu_sel); end
    checks++; if ({flag_c, flag_v, illegal} !== 3'b000) begin errors++; $display("FAIL mid_flags got %b want 000", {flag_c, flag_v, illegal}); end
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], v);
      checks++; if (v !== 4'h0) begin errors++; $display("FAIL mid_reg%0d got %h want 0", i, v); end
    end
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr_op = 4'h0; instr_rd = 2'd0; instr_rs1 = 2'd0; instr_rs2 = 2'd0; instr_imm = 4'h0;
    dbg_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_ldi;
    test_add;
    test_sub;
    test_mul;
    test_illegal;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Instruction-level controller for the 4-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and owns a 4-entry x 4-bit register file.
- Per instruction: reads operands, drives the ALU's A/B/Sel inputs, captures F3/F4/C/V, writes back, and reports completion.
- Sits between the instruction source (switches/ROM sequencer on the FPGA) and the combinational ALU, which is instantiated alongside it at top level.

Parameters:
- NREG, 4, register-file depth; fixed at 4 (2-bit register addresses).
- W, 4, datapath width; fixed at 4 (matches the ALU).

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  sequencer can accept an instruction
- instr_op  in  4  opcode: ALU Sel code, or 0000 = LDI
- instr_rd  in  2  destination register
- instr_rs1  in  2  source A register
- instr_rs2  in  2  source B register
- instr_imm  in  4  immediate for LDI
- alu_a  out  4  to ALU A (registered)
- alu_b  out  4  to ALU B (registered)
- alu_sel  out  4  to ALU Sel (registered)
- alu_f3  in  4  ALU low result
- alu_f4  in  4  ALU high result (MUL only)
- alu_c  in  1  ALU carry
- alu_v  in  1  ALU overflow
- done  out  1  one-cycle pulse when an instruction retires
- flag_c  out  1  last captured carry
- flag_v  out  1  last captured overflow
- illegal  out  1  sticky: an illegal opcode was accepted
- dbg_sel  in  2  debug register read address
- dbg_data  out  4  reg[dbg_sel], combinational

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE; all regs=0; alu_a=alu_b=0; alu_sel=4'b1111; done=0; flag_c=flag_v=0; illegal=0.
- Reset mid-operation: abandon the instruction; no writeback; no done pulse.
- Legal ALU opcodes:
  - 0001 ADD, 0011 SUB, 0111 MUL, 1000 NAND, 1001 NOR, 1011 XOR.
  - 1111, 1110, 1100: legal "zero" ops; ALU returns 0.
- LDI: 0000.
- Illegal opcodes: all other codes (0010, 0100, 0101, 0110, 1010, 1101).
- FSM states: IDLE, OPER, EXEC, WB.
- IDLE:
  - instr_ready=1. All other states: instr_ready=0.
  - On instr_valid&&instr_ready: latch op/rd/rs1/rs2/imm, go to OPER.
- OPER:
  - Register alu_a=reg[rs1], alu_b=reg[rs2]; alu_sel=op for legal ALU ops, else 1111.
  - Next state: EXEC for legal ALU ops; WB for LDI or illegal.
- EXEC:
  - ALU outputs are stable; capture F3, F4, C, V into internal holding registers.
  - Go to WB.
- WB:
  - ALU op: reg[rd]<=F3; flag_c<=C; flag_v<=V.
  - MUL: additionally reg[(rd+1) mod 4]<=F4; rd=3 wraps the high nibble to reg0. If rs1 or rs2 = rd+1, the operands were already captured, so no hazard.
  - LDI: reg[rd]<=imm; flags unchanged.
  - Illegal: no register or flag write; illegal<=1, held until rst.
  - All cases: done=1 for this cycle; alu_sel<=1111; go to IDLE.
- Latency, accept cycle T -> done: ALU op = T+3; LDI/illegal = T+2.
- Throughput: ALU op = 1 instruction per 4 cycles; LDI/illegal = 1 per 3 cycles.
- instr_* is ignored outside IDLE; the source must hold valid until ready.
- dbg_data reflects a WB write from the cycle after that WB edge.
- Arithmetic: all wrap modulo 16; C/V semantics are the ALU's, captured unmodified. Non-add/sub ops capture C=V=0 from the ALU.

Test Plan:
- Reset, then LDI r0=5 and LDI r1=3 -> each done at accept+2; dbg r0=5, r1=3; flags 0; instr_ready high again the cycle after done.
- ADD r2=r0+r1 with r0=7, r1=9 -> alu_sel=0001 during EXEC; r2=0, flag_c=1, flag_v=0; done at accept+3.
- SUB r2=r0-r1 with 2-3 -> r2=F (4'b1111); flags equal the ALU's C/V for these operands.
- MUL rd=3, r0=0xF, r1=0xF -> r3=1, r0=E (wraps); C=V=0.
- Illegal op 0101 -> done at accept+2, illegal=1, no register or flag change; a following XOR (A=0xA, B=0x6 -> 0xC) still executes and illegal stays 1.
- Assert rst during EXEC of ADD -> no done; all regs and flags 0; alu_sel=1111; instr_ready=1 the next cycle. Hold instr_valid across busy cycles -> exactly one acceptance.
